// File: rtl/clken_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Holds the FSM state encoding, the default width and config legality check.
package clken_pkg;

  localparam int ACC_W_DEF = 8;

  typedef enum logic [1:0] {
    LOCKING = 2'd0,
    RUN     = 2'd1,
    PWRDN   = 2'd2
  } state_t;

  function automatic logic cfg_legal(
    input logic [2:0]  chan,
    input logic [31:0] num,
    input logic [31:0] den,
    input int          n_ch
  );
    return (32'(chan) < n_ch)
        && (den != 32'd0)
        && (num <= den);
  endfunction

endpackage

// File: rtl/clken_chan.sv
// One fractional enable channel: accumulate num, emit a pulse on wrap past den.
// Ports: clk, rst (sync, high), clr (zero acc), en (advance), num, den, ce.
module clken_chan #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  output logic             ce
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] rem;
  logic             hit;

  // Extra bit keeps acc+num exact when both are near full scale.
  assign sum = {1'b0, acc} + {1'b0, num};
  assign hit = (num != '0) && (sum >= {1'b0, den});
  // On a hit the true difference is below den, so the low bits suffice.
  assign rem = sum[ACC_W-1:0] - den;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (en) begin
      if (hit) begin
        acc <= rem;
        ce  <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
        ce  <= 1'b0;
      end
    end else begin
      ce <= 1'b0;
    end
  end

endmodule

// File: rtl/clken_gen_multi.sv
// N-channel fractional clock-enable generator with lock, power-down and config.
// Ports: refclk, rst, pwrdwn, cfg_* handshake, cfg_err, ce_out[N_CH], locked.
module clken_gen_multi
  import clken_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int LOCK_DELAY = 16,
  parameter logic [N_CH*ACC_W-1:0] INIT_NUM = {8'd1, 8'd1, 8'd1},
  parameter logic [N_CH*ACC_W-1:0] INIT_DEN = {8'd1, 8'd2, 8'd4}
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pwrdwn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_chan,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  output logic             cfg_err,
  output logic [N_CH-1:0]  ce_out,
  output logic             locked
);

  localparam int CNT_W =
    (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(LOCK_DELAY - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             locked_d;
  logic             ready_d;
  logic             err_d;

  logic [ACC_W-1:0] num_q [N_CH];
  logic [ACC_W-1:0] den_q [N_CH];

  logic acc_fire;
  logic legal;
  logic legal_acc;
  logic go_pd;
  logic wake;
  logic restart;
  logic lock_done;
  logic ch_en;
  logic ch_clr;

  // Power-down input blocks acceptance even if ready was already high.
  assign acc_fire  = cfg_valid && cfg_ready && !pwrdwn;
  assign legal     = cfg_legal(cfg_chan, 32'(cfg_num),
                               32'(cfg_den), N_CH);
  assign legal_acc = acc_fire && legal;

  assign go_pd     = pwrdwn;
  assign wake      = !pwrdwn && (state_q == PWRDN);
  assign restart   = legal_acc && (state_q != PWRDN);
  assign lock_done = !pwrdwn && !legal_acc
                  && (state_q == LOCKING)
                  && (cnt_q == CNT_LAST);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= LOCKING;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      go_pd:     state_d = PWRDN;
      wake:      state_d = LOCKING;
      restart:   state_d = LOCKING;
      lock_done: state_d = RUN;
      default:   state_d = state_q;
    endcase
  end

  always_comb begin
    cnt_d    = '0;
    locked_d = (state_d == RUN);
    ready_d  = (state_d != PWRDN) && !acc_fire;
    err_d    = acc_fire && !legal;
    if ((state_q == LOCKING) && (state_d == LOCKING)
        && !legal_acc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      locked    <= locked_d;
      cfg_ready <= ready_d;
      cfg_err   <= err_d;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        num_q[i] <= INIT_NUM[i*ACC_W +: ACC_W];
        den_q[i] <= INIT_DEN[i*ACC_W +: ACC_W];
      end
    end else if (legal_acc) begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_chan == 3'(i)) begin
          num_q[i] <= cfg_num;
          den_q[i] <= cfg_den;
        end
      end
    end
  end

  // Channels advance on the edge entering or staying in RUN, so the
  // first RUN cycle already shows the index-0 pulse; any other next
  // state zeroes every accumulator, realigning all phases.
  assign ch_en  = (state_d == RUN);
  assign ch_clr = !ch_en;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clken_chan #(
      .ACC_W (ACC_W)
    ) u_chan (
      .clk (refclk),
      .rst (rst),
      .clr (ch_clr),
      .en  (ch_en),
      .num (num_q[g]),
      .den (den_q[g]),
      .ce  (ce_out[g])
    );
  end

endmodule

// File: tb/tb_clken_gen_multi.sv
// Scoreboard bench for clken_gen_multi: drives config/power stimulus and
// checks locked, ce_out, cfg_ready and cfg_err every cycle.
module tb_clken_gen_multi;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int LD = 16;

  logic         refclk = 1'b0;
  logic         rst = 1'b1;
  logic         pwrdwn = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [2:0]   cfg_chan = '0;
  logic [W-1:0] cfg_num = '0;
  logic [W-1:0] cfg_den = '0;
  logic         cfg_err;
  logic [N-1:0] ce_out;
  logic         locked;

  always #5 refclk = ~refclk;

  clken_gen_multi #(
    .N_CH       (N),
    .ACC_W      (W),
    .LOCK_DELAY (LD),
    .INIT_NUM   ({8'd1, 8'd1, 8'd1}),
    .INIT_DEN   ({8'd1, 8'd2, 8'd4})
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pwrdwn    (pwrdwn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cfg_err   (cfg_err),
    .ce_out    (ce_out),
    .locked    (locked)
  );

  typedef struct packed {
    logic         lk;
    logic [N-1:0] ce;
    logic         rdy;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   n_cyc  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %0h want %0h",
               tag, n_cyc, got, exp);
    end
  endtask

  // Spec-level model: mode 0=LOCKING 1=RUN 2=PWRDN.
  int   m_mode = 0;
  int   m_cnt  = 0;
  int   m_run  = 0;
  int   m_num[N];
  int   m_den[N];
  logic m_rdy  = 1'b0;

  // Pulse k of a num/den stream: floor count of num/den crosses.
  function automatic bit pulse(int k, int n, int d);
    return ((k + 1) * n) / d != (k * n) / d;
  endfunction

  task automatic cyc(input logic r, input logic pd,
                     input logic v, input int ch,
                     input int n, input int d);
    exp_t e;
    logic acc, lg, err;
    @(negedge refclk);
    rst       = r;
    pwrdwn    = pd;
    cfg_valid = v;
    cfg_chan  = 3'(ch);
    cfg_num   = W'(n);
    cfg_den   = W'(d);
    err = 1'b0;
    if (r) begin
      m_mode = 0;
      m_cnt  = 0;
      m_run  = 0;
      m_num  = '{1, 1, 1};
      m_den  = '{4, 2, 1};
      m_rdy  = 1'b0;
    end else begin
      acc = v && m_rdy && !pd;
      lg  = (ch < N) && (d != 0) && (n <= d);
      err = acc && !lg;
      if (pd) begin
        m_mode = 2;
      end else if (m_mode == 2) begin
        m_mode = 0;
        m_cnt  = 0;
      end else if (acc && lg) begin
        m_num[ch] = n;
        m_den[ch] = d;
        m_mode = 0;
        m_cnt  = 0;
      end else if (m_mode == 0) begin
        if (m_cnt == LD - 1) begin
          m_mode = 1;
          m_run  = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_run++;
      end
      m_rdy = (m_mode != 2) && !acc;
    end
    e.lk  = (m_mode == 1);
    e.rdy = m_rdy;
    e.err = err;
    for (int i = 0; i < N; i++)
      e.ce[i] = (m_mode == 1)
             && pulse(m_run, m_num[i], m_den[i]);
    sb.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  always begin : mon
    exp_t e;
    @(posedge refclk);
    #1;
    n_cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("locked", 32'(locked), 32'(e.lk));
      chk("ce_out", 32'(ce_out), 32'(e.ce));
      chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
      chk("cfg_err", 32'(cfg_err), 32'(e.err));
    end
  end

  initial begin
    m_num = '{1, 1, 1};
    m_den = '{4, 2, 1};
    // Reset, with a config request that must be discarded.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 2, 5);
    cyc(1, 0, 0, 0, 0, 0);
    idle(LD + 12);
    // Reprogram ch0 to 2/5 and watch the realigned pattern.
    cyc(0, 0, 1, 0, 2, 5);
    idle(LD + 14);
    // Illegal requests: num>den, den=0, chan out of range.
    cyc(0, 0, 1, 0, 5, 3);
    idle(2);
    cyc(0, 0, 1, 1, 1, 0);
    idle(2);
    cyc(0, 0, 1, 3, 1, 2);
    idle(6);
    // Zero numerator silences ch1.
    cyc(0, 0, 1, 1, 0, 3);
    idle(LD + 20);
    // Power-down with a config request held throughout.
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 2, 1, 3);
    idle(LD + 10);
    // Back-to-back requests, last one full-scale on ch2.
    cyc(0, 0, 1, 2, 1, 3);
    cyc(0, 0, 1, 2, 2, 3);
    cyc(0, 0, 1, 2, 255, 255);
    cyc(0, 0, 1, 2, 255, 255);
    idle(LD + 12);
    @(posedge refclk);
    #2;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/clken_gen_multi.md
Name: clken_gen_multi

Overview:
- Parametrised N-channel fractional clock-enable generator.
- Replaces fixed-ratio PLL output clocks with single-clock-domain enable pulses. Each channel's ratio NUM/DEN of `refclk` is reprogrammable at runtime.
- Provides a PLL-like `locked` indication, a power-down mode, and phase realignment of all channels on every reconfiguration.
- Sits beside the core clock wrapper. Video, CPU and audio logic run on `refclk` and qualify on `ce_out` bits.

Parameters:
- `N_CH`, 3: number of enable channels (1..8).
- `ACC_W`, 8: width of NUM, DEN and accumulators.
- `LOCK_DELAY`, 16: cycles spent in LOCKING before `locked` asserts (>=1).
- `INIT_NUM`, {8'd1,8'd1,8'd1}: packed per-channel reset numerators, channel 0 in the LSBs.
- `INIT_DEN`, {8'd1,8'd2,8'd4}: packed per-channel reset denominators (ch0=1/4, ch1=1/2, ch2=1/1).

Ports:
- `refclk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pwrdwn`, in, 1: level; forces PWRDN state while high.
- `cfg_valid`, in, 1: config request.
- `cfg_ready`, out, 1: config accepted when `cfg_valid` && `cfg_ready`.
- `cfg_chan`, in, 3: target channel.
- `cfg_num`, in, `ACC_W`: new numerator.
- `cfg_den`, in, `ACC_W`: new denominator.
- `cfg_err`, out, 1: one-cycle pulse; the accepted config was rejected.
- `ce_out`, out, `N_CH`: per-channel one-cycle enable pulses.
- `locked`, out, 1: high in RUN only.

Behaviour:
- States: LOCKING, RUN, PWRDN. All outputs are registered.
- Reset (`rst` sampled high):
  - state <= LOCKING; lock counter <= 0.
  - Per-channel num/den <= INIT values; all accumulators <= 0.
  - `ce_out`=0, `locked`=0, `cfg_err`=0, `cfg_ready`=0.
  - `rst` has priority over `pwrdwn` and config.
- LOCKING:
  - Counter increments each cycle. When the counter equals `LOCK_DELAY`-1, next state is RUN.
  - Accumulators are held at 0. `ce_out`=0.
- RUN: `locked`=1. Per channel, computed in `ACC_W`+1 bits: s = acc + num.
  - If num != 0 and s >= den: acc <= s - den and `ce_out`[i] <= 1.
  - Else: acc <= s (num=0 leaves acc at 0) and `ce_out`[i] <= 0.
  - First pulse of channel i occurs on RUN cycle index ceil(den/num)-1, counting from 0. Pulse rate is exactly num/den over den cycles.
- PWRDN:
  - Entered from any state on the cycle after `pwrdwn` is sampled high.
  - `ce_out`=0, `locked`=0, `cfg_ready`=0.
  - On `pwrdwn` low: go to LOCKING with counter 0 and accumulators 0.
- `cfg_ready`=1 in LOCKING and RUN when `pwrdwn` is low, and not in the cycle after an acceptance. This gives one config per 2 cycles.
- Acceptance validity:
  - Accepted config is legal iff `cfg_chan` < `N_CH`, `cfg_den` != 0, and `cfg_num` <= `cfg_den`.
  - Illegal config: no state change; `cfg_err`=1 in the next cycle.
  - Legal config: next cycle the channel registers are updated, all accumulators clear, state <= LOCKING, counter <= 0, `locked`=0, `ce_out`=0.
  - A legal config accepted in LOCKING restarts the count.
- Timing: legal accept at cycle t gives `locked` low at t+1 and high at t+1+`LOCK_DELAY`.
- Simultaneous events:
  - `cfg_valid` with `pwrdwn` high: not accepted (`cfg_ready`=0).
  - `rst` with `cfg_valid`: config is discarded.
- Config registers persist through PWRDN. Only `rst` restores the INIT values.

Decomposition:
- Package `clken_pkg`:
  - state enum {LOCKING, RUN, PWRDN}.
  - `ACC_W` default.
  - Function `cfg_legal(chan, num, den, n_ch)`.
- One sub-module, `clken_chan`:
  - Accumulator, compare and pulse for one channel, with clear and enable inputs.
  - Instantiated `N_CH` times by generate.

Test Plan:
- Reset with defaults:
  - `locked` rises exactly 16 cycles after `rst` falls.
  - In the next 8 RUN cycles: `ce_out`[2] is 1 every cycle, `ce_out`[1] is 1 at indices 1,3,5,7, and `ce_out`[0] is 1 at indices 3,7.
- Program ch0 num=2, den=5:
  - `locked` drops at t+1 and returns at t+17.
  - Ch0 pulses at RUN indices 2,4,7,9 (4 pulses per 10 cycles).
  - All channels restart phase-aligned.
- Illegal configs, each -> `cfg_err` pulse, `locked` stays 1, `ce_out` pattern unchanged:
  - num=5, den=3.
  - den=0.
  - chan=3.
- num=0 on ch1 -> `ce_out`[1] stays 0 indefinitely while other channels run.
- `pwrdwn` asserted mid-RUN for 10 cycles:
  - Next cycle `locked`=0, `ce_out`=0, `cfg_ready`=0; a `cfg_valid` held high during this time is ignored.
  - After release: `locked` after 16 cycles with the previous configuration.
- Back-to-back `cfg_valid` with 8'hFF/8'hFF:
  - `cfg_ready` alternates so only every second cycle accepts.
  - The final config wins, and ch2 pulses every cycle with no overflow at `ACC_W`=8.
